// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU-op codes, funct constants, ALU control and FSM encodings
// for the execute stage. Purely declarative, no ports.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_NOP
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } ex_state_e;

  // EX/MEM control payload
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } exmem_ctrl_t;

  // ALUOp/funct to ALU operation; unknown funct maps to NOP
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
    alu_ctrl_e c;
    c = ALU_NOP;
    case (alu_op)
      ALUOP_ADD, ALUOP_ADDI: c = ALU_ADD;
      ALUOP_SUB:             c = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: c = ALU_ADD;
          FUNCT_SUB: c = ALU_SUB;
          FUNCT_AND: c = ALU_AND;
          FUNCT_OR:  c = ALU_OR;
          FUNCT_SLT: c = ALU_SLT;
          FUNCT_MUL: c = ALU_MUL;
          default:   c = ALU_NOP;
        endcase
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier, MUL_BITS multiplier bits per cycle,
// low DATA_W bits of the product.
// Ports: clk, rst (sync active-low), start (accepted when idle; performs
// iteration 0 on that edge), a, b operands; busy (registered), done_c
// (combinational, high on the edge that completes the final iteration),
// product_c (combinational product valid while done_c).
module ex_mul_iter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done_c,
  output logic [DATA_W-1:0] product_c
);

  localparam int unsigned ITER  = DATA_W / MUL_BITS;
  localparam int unsigned CNT_W = $clog2(ITER);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] pp_start;
  logic [DATA_W-1:0] pp_iter;

  // Partial product of m with a MUL_BITS-wide multiplier digit
  function automatic logic [DATA_W-1:0] partial(input logic [DATA_W-1:0]   m,
                                                input logic [MUL_BITS-1:0] d);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int j = 0; j < int'(MUL_BITS); j++) begin
      if (d[j]) s = s + (m << j);
    end
    return s;
  endfunction

  assign pp_start  = partial(a, b[MUL_BITS-1:0]);
  assign pp_iter   = partial(a_q, b_q[MUL_BITS-1:0]);
  assign product_c = acc_q + pp_iter;
  assign done_c    = busy && (cnt == CNT_W'(ITER - 1));

  // Operand/accumulator/counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (busy) begin
      acc_q <= product_c;
      a_q   <= a_q << MUL_BITS;
      b_q   <= b_q >> MUL_BITS;
      if (done_c) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= CNT_W'(1);
      acc_q <= pp_start;
      a_q   <= a << MUL_BITS;
      b_q   <= b >> MUL_BITS;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with EX/MEM pipeline register. Operand forwarding
// (EX/MEM over MEM/WB), ALU-control decode, destination select and an
// iterative MUL that raises stall_out while it runs.
// Ports: clk, rst (sync active-low); ID/EX controls, operands and register
// addresses (*_in); MEM/WB forwarding source (memwb_*); EX/MEM outputs
// (RegWrite/MemtoReg/MemRead/MemWrite/ALUResult/StoreData/Rd_addr_out);
// stall_out (combinational) holds PC and IF/ID.
// Build option: define EX_OVF_EN to trap signed add/sub overflow (funct form)
// by dropping RegWrite_out and setting the sticky ovf_out port.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              ALUSrc_in,
  input  logic              RegDst_in,
  input  logic [1:0]        ALUOp_in,
  input  logic [DATA_W-1:0] RegRsData_in,
  input  logic [DATA_W-1:0] RegRtData_in,
  input  logic [DATA_W-1:0] Immediate_in,
  input  logic [4:0]        instr_Rs_addr_in,
  input  logic [4:0]        instr_Rt_addr_a_in,
  input  logic [4:0]        instr_Rt_addr_b_in,
  input  logic [4:0]        instr_Rd_addr_in,
  input  logic              memwb_RegWrite_in,
  input  logic [4:0]        memwb_Rd_addr_in,
  input  logic [DATA_W-1:0] memwb_WriteData_in,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic              MemRead_out,
  output logic              MemWrite_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [DATA_W-1:0] StoreData_out,
  output logic [4:0]        Rd_addr_out,
  output logic              stall_out
`ifdef EX_OVF_EN
  ,
  output logic              ovf_out
`endif
);

  localparam int unsigned MSB = DATA_W - 1;

  ex_state_e         state, state_d;
  exmem_ctrl_t       ctrl_q, ctrl_d;
  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] store_d;
  logic [4:0]        rd_d;
  logic [4:0]        cap_rd, cap_rd_d;
  logic              cap_rw, cap_rw_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        dest;
  alu_ctrl_e         alu_ctrl;
  logic              is_mul;

  logic              mul_start;
  logic              mul_busy;
  logic              mul_done_c;
  logic [DATA_W-1:0] mul_product_c;

`ifdef EX_OVF_EN
  logic ovf;
  logic ovf_d;
`endif

  // Forward select: EX/MEM first, then MEM/WB, never for r0
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0]        addr,
                                                input logic [DATA_W-1:0] reg_val,
                                                input logic              exm_rw,
                                                input logic [4:0]        exm_rd,
                                                input logic [DATA_W-1:0] exm_val,
                                                input logic              wb_rw,
                                                input logic [4:0]        wb_rd,
                                                input logic [DATA_W-1:0] wb_val);
    if (exm_rw && (exm_rd != 5'd0) && (exm_rd == addr)) return exm_val;
    else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == addr)) return wb_val;
    else return reg_val;
  endfunction

  assign fwd_rs = fwd_sel(instr_Rs_addr_in, RegRsData_in, RegWrite_out, Rd_addr_out,
                          ALUResult_out, memwb_RegWrite_in, memwb_Rd_addr_in,
                          memwb_WriteData_in);
  assign fwd_rt = fwd_sel(instr_Rt_addr_a_in, RegRtData_in, RegWrite_out, Rd_addr_out,
                          ALUResult_out, memwb_RegWrite_in, memwb_Rd_addr_in,
                          memwb_WriteData_in);

  assign op_b     = ALUSrc_in ? Immediate_in : fwd_rt;
  assign dest     = RegDst_in ? instr_Rd_addr_in : instr_Rt_addr_b_in;
  assign alu_ctrl = alu_decode(ALUOp_in, Immediate_in[5:0]);
  assign is_mul   = (alu_ctrl == ALU_MUL);
  assign sum      = fwd_rs + op_b;
  assign diff     = fwd_rs - op_b;

  // Single-cycle ALU; MUL and NOP produce 0 here
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_AND: alu_res = fwd_rs & op_b;
      ALU_OR:  alu_res = fwd_rs | op_b;
      ALU_SLT: alu_res = DATA_W'($signed(fwd_rs) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

`ifdef EX_OVF_EN
  // Signed overflow, funct-form add/sub only
  always_comb begin
    ovf = 1'b0;
    if (ALUOp_in == ALUOP_FUNCT) begin
      if (alu_ctrl == ALU_ADD)
        ovf = (fwd_rs[MSB] == op_b[MSB]) && (sum[MSB] != fwd_rs[MSB]);
      else if (alu_ctrl == ALU_SUB)
        ovf = (fwd_rs[MSB] != op_b[MSB]) && (diff[MSB] != fwd_rs[MSB]);
    end
  end
`endif

  // The multiply uses forwarded Rt, not the immediate path
  ex_mul_iter #(
    .DATA_W   (DATA_W),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .a         (fwd_rs),
    .b         (fwd_rt),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  // Stall covers the decode cycle plus every busy cycle; forced low in reset
  assign stall_out = rst && ((state == ST_IDLE && is_mul) || mul_busy);

  // Next state and EX/MEM next values; bubble unless a result is ready
  always_comb begin
    state_d   = state;
    ctrl_d    = '0;
    result_d  = '0;
    store_d   = '0;
    rd_d      = '0;
    cap_rd_d  = cap_rd;
    cap_rw_d  = cap_rw;
    mul_start = 1'b0;
`ifdef EX_OVF_EN
    ovf_d     = ovf_out;
`endif
    case (state)
      ST_IDLE: begin
        if (is_mul) begin
          state_d   = ST_BUSY;
          mul_start = 1'b1;
          cap_rd_d  = dest;
          cap_rw_d  = RegWrite_in;
        end else begin
          ctrl_d.reg_write  = RegWrite_in && (alu_ctrl != ALU_NOP);
          ctrl_d.mem_to_reg = MemtoReg_in;
          ctrl_d.mem_read   = MemRead_in;
          ctrl_d.mem_write  = MemWrite_in;
          result_d          = alu_res;
          store_d           = fwd_rt;
          rd_d              = dest;
`ifdef EX_OVF_EN
          if (ovf) begin
            ctrl_d.reg_write = 1'b0;
            ovf_d            = 1'b1;
          end
`endif
        end
      end
      ST_BUSY: begin
        if (mul_done_c) begin
          state_d          = ST_IDLE;
          ctrl_d.reg_write = cap_rw;
          result_d         = mul_product_c;
          rd_d             = cap_rd;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture and EX/MEM registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      ctrl_q        <= '0;
      ALUResult_out <= '0;
      StoreData_out <= '0;
      Rd_addr_out   <= '0;
      cap_rd        <= '0;
      cap_rw        <= 1'b0;
`ifdef EX_OVF_EN
      ovf_out       <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      ctrl_q        <= ctrl_d;
      ALUResult_out <= result_d;
      StoreData_out <= store_d;
      Rd_addr_out   <= rd_d;
      cap_rd        <= cap_rd_d;
      cap_rw        <= cap_rw_d;
`ifdef EX_OVF_EN
      ovf_out       <= ovf_d;
`endif
    end
  end

  assign RegWrite_out = ctrl_q.reg_write;
  assign MemtoReg_out = ctrl_q.mem_to_reg;
  assign MemRead_out  = ctrl_q.mem_read;
  assign MemWrite_out = ctrl_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage (DATA_W=32, MUL_BITS=1).
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in, RegDst_in;
  logic [1:0]  ALUOp_in;
  logic [31:0] RegRsData_in, RegRtData_in, Immediate_in;
  logic [4:0]  instr_Rs_addr_in, instr_Rt_addr_a_in, instr_Rt_addr_b_in, instr_Rd_addr_in;
  logic        memwb_RegWrite_in;
  logic [4:0]  memwb_Rd_addr_in;
  logic [31:0] memwb_WriteData_in;
  logic        RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
  logic [31:0] ALUResult_out, StoreData_out;
  logic [4:0]  Rd_addr_out;
  logic        stall_out;
`ifdef EX_OVF_EN
  logic        ovf_out;
`endif

  int checks   = 0;
  int failures = 0;
  int n_edges;
  int n_stall;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_BAD = 6'b000111;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                (clk),
    .rst                (rst),
    .RegWrite_in        (RegWrite_in),
    .MemtoReg_in        (MemtoReg_in),
    .MemRead_in         (MemRead_in),
    .MemWrite_in        (MemWrite_in),
    .ALUSrc_in          (ALUSrc_in),
    .RegDst_in          (RegDst_in),
    .ALUOp_in           (ALUOp_in),
    .RegRsData_in       (RegRsData_in),
    .RegRtData_in       (RegRtData_in),
    .Immediate_in       (Immediate_in),
    .instr_Rs_addr_in   (instr_Rs_addr_in),
    .instr_Rt_addr_a_in (instr_Rt_addr_a_in),
    .instr_Rt_addr_b_in (instr_Rt_addr_b_in),
    .instr_Rd_addr_in   (instr_Rd_addr_in),
    .memwb_RegWrite_in  (memwb_RegWrite_in),
    .memwb_Rd_addr_in   (memwb_Rd_addr_in),
    .memwb_WriteData_in (memwb_WriteData_in),
    .RegWrite_out       (RegWrite_out),
    .MemtoReg_out       (MemtoReg_out),
    .MemRead_out        (MemRead_out),
    .MemWrite_out       (MemWrite_out),
    .ALUResult_out      (ALUResult_out),
    .StoreData_out      (StoreData_out),
    .Rd_addr_out        (Rd_addr_out),
    .stall_out          (stall_out)
`ifdef EX_OVF_EN
    ,
    .ovf_out            (ovf_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic r_op(input logic [5:0] f, input logic [4:0] rsa, input logic [31:0] rsd,
                      input logic [4:0] rta, input logic [31:0] rtd, input logic [4:0] rda);
    RegWrite_in        = 1'b1;
    MemtoReg_in        = 1'b0;
    MemRead_in         = 1'b0;
    MemWrite_in        = 1'b0;
    ALUSrc_in          = 1'b0;
    RegDst_in          = 1'b1;
    ALUOp_in           = 2'b10;
    Immediate_in       = {26'd0, f};
    instr_Rs_addr_in   = rsa;
    RegRsData_in       = rsd;
    instr_Rt_addr_a_in = rta;
    instr_Rt_addr_b_in = rta;
    RegRtData_in       = rtd;
    instr_Rd_addr_in   = rda;
  endtask

  task automatic memwb(input logic rw, input logic [4:0] rd, input logic [31:0] d);
    memwb_RegWrite_in  = rw;
    memwb_Rd_addr_in   = rd;
    memwb_WriteData_in = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rw"},  {31'd0, RegWrite_out}, 32'd0);
    chk({tag, "_m2r"}, {31'd0, MemtoReg_out}, 32'd0);
    chk({tag, "_mr"},  {31'd0, MemRead_out},  32'd0);
    chk({tag, "_mw"},  {31'd0, MemWrite_out}, 32'd0);
    chk({tag, "_res"}, ALUResult_out, 32'd0);
    chk({tag, "_st"},  StoreData_out, 32'd0);
    chk({tag, "_rd"},  {27'd0, Rd_addr_out}, 32'd0);
`ifdef EX_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf_out}, 32'd0);
`endif
  endtask

  // Runs BUSY edges until the product is written (bounded); counts edges and
  // pre-edge stall cycles. The start edge is taken by the caller.
  task automatic wait_mul(output int n, output int st);
    n  = 0;
    st = 0;
    do begin
      #1;
      if (stall_out) st++;
      tick();
      n++;
    end while (RegWrite_out !== 1'b1 && n < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with garbage inputs, including a mul decode
    rst = 1'b0;
    r_op(F_MUL, 5'd3, 32'hDEADBEEF, 5'd4, 32'h12345678, 5'd9);
    MemRead_in = 1'b1;
    MemWrite_in = 1'b1;
    memwb(1'b1, 5'd3, 32'hCAFEF00D);
    #1;
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    tick();
    tick();
    chk_zero("rst");
    chk("rst_stall2", {31'd0, stall_out}, 32'd0);

    // Basic add
    rst = 1'b1;
    memwb(1'b0, 5'd0, 32'd0);
    r_op(F_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    #1;
    chk("add_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("add_res", ALUResult_out, 32'd12);
    chk("add_rw", {31'd0, RegWrite_out}, 32'd1);
    chk("add_rd", {27'd0, Rd_addr_out}, 32'd3);
    chk("add_st", StoreData_out, 32'd7);

    // EX/MEM forward beats MEM/WB on the same register
    r_op(F_SUB, 5'd3, 32'd100, 5'd2, 32'd7, 5'd4);
    memwb(1'b1, 5'd3, 32'd999);
    tick();
    chk("sub_fwd_exm", ALUResult_out, 32'd5);

    // Forward into Rt / StoreData
    memwb(1'b0, 5'd0, 32'd0);
    r_op(F_ADD, 5'd1, 32'd1, 5'd4, 32'd0, 5'd5);
    tick();
    chk("rt_fwd_res", ALUResult_out, 32'd6);
    chk("rt_fwd_st", StoreData_out, 32'd5);

    // r0 is never forwarded from either source
    r_op(F_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0);
    tick();
    chk("r0_rd", {27'd0, Rd_addr_out}, 32'd0);
    r_op(F_ADD, 5'd0, 32'd20, 5'd2, 32'd1, 5'd6);
    memwb(1'b1, 5'd0, 32'd555);
    tick();
    chk("r0_nofwd", ALUResult_out, 32'd21);

    // MEM/WB forward
    r_op(F_ADD, 5'd7, 32'd1, 5'd8, 32'd2, 5'd9);
    memwb(1'b1, 5'd7, 32'd40);
    tick();
    chk("wb_fwd", ALUResult_out, 32'd42);
    memwb(1'b0, 5'd0, 32'd0);

    // slt signed, both orders
    r_op(F_SLT, 5'd10, 32'hFFFFFFFF, 5'd11, 32'd1, 5'd12);
    tick();
    chk("slt_lt", ALUResult_out, 32'd1);
    r_op(F_SLT, 5'd10, 32'd1, 5'd11, 32'hFFFFFFFF, 5'd13);
    tick();
    chk("slt_ge", ALUResult_out, 32'd0);

    // and / or
    r_op(F_AND, 5'd10, 32'h0000F0F0, 5'd11, 32'h0000FF00, 5'd14);
    tick();
    chk("and", ALUResult_out, 32'h0000F000);
    r_op(F_OR, 5'd10, 32'h0000F0F0, 5'd11, 32'h0000FF00, 5'd15);
    tick();
    chk("or", ALUResult_out, 32'h0000FFF0);

    // Unknown funct drops RegWrite and zeroes the result
    r_op(F_BAD, 5'd10, 32'd3, 5'd11, 32'd4, 5'd16);
    tick();
    chk("bad_res", ALUResult_out, 32'd0);
    chk("bad_rw", {31'd0, RegWrite_out}, 32'd0);
    chk("bad_rd", {27'd0, Rd_addr_out}, 32'd16);

    // Immediate path, ALUOp 00, RegDst=0, memory controls pass through
    r_op(6'd0, 5'd17, 32'd10, 5'd18, 32'd99, 5'd20);
    ALUOp_in           = 2'b00;
    ALUSrc_in          = 1'b1;
    Immediate_in       = 32'hFFFFFFFC;
    RegDst_in          = 1'b0;
    instr_Rt_addr_b_in = 5'd19;
    MemRead_in         = 1'b1;
    MemtoReg_in        = 1'b1;
    tick();
    chk("imm_res", ALUResult_out, 32'd6);
    chk("imm_rd", {27'd0, Rd_addr_out}, 32'd19);
    chk("imm_mr", {31'd0, MemRead_out}, 32'd1);
    chk("imm_m2r", {31'd0, MemtoReg_out}, 32'd1);
    chk("imm_mw", {31'd0, MemWrite_out}, 32'd0);

    // ALUOp 01 subtract
    r_op(6'd0, 5'd17, 32'd10, 5'd18, 32'd3, 5'd20);
    ALUOp_in = 2'b01;
    tick();
    chk("op01_sub", ALUResult_out, 32'd7);

    // MUL 7*6, following add consumes the product
    r_op(F_MUL, 5'd21, 32'd7, 5'd22, 32'd6, 5'd23);
    #1;
    chk("mul_stall0", {31'd0, stall_out}, 32'd1);
    tick();
    chk("mul_bubble0", {31'd0, RegWrite_out}, 32'd0);
    r_op(F_ADD, 5'd23, 32'd0, 5'd24, 32'd100, 5'd25);
    wait_mul(n_edges, n_stall);
    chk("mul_edges", 32'(n_edges), 32'd31);
    chk("mul_stalls", 32'(n_stall + 1), 32'd32);
    chk("mul_res", ALUResult_out, 32'd42);
    chk("mul_rw", {31'd0, RegWrite_out}, 32'd1);
    chk("mul_rd", {27'd0, Rd_addr_out}, 32'd23);
    chk("mul_mr", {31'd0, MemRead_out}, 32'd0);
    #1;
    chk("mul_stall_end", {31'd0, stall_out}, 32'd0);
    tick();
    chk("mul_fwd", ALUResult_out, 32'd142);
    chk("mul_fwd_rd", {27'd0, Rd_addr_out}, 32'd25);

    // Back-to-back MULs: 0xFFFFFFFF*2, then 3*5
    r_op(F_MUL, 5'd26, 32'hFFFFFFFF, 5'd27, 32'd2, 5'd28);
    tick();
    r_op(F_MUL, 5'd29, 32'd3, 5'd30, 32'd5, 5'd31);
    wait_mul(n_edges, n_stall);
    chk("mulw_edges", 32'(n_edges), 32'd31);
    chk("mulw_res", ALUResult_out, 32'hFFFFFFFE);
    chk("mulw_rd", {27'd0, Rd_addr_out}, 32'd28);
    #1;
    chk("b2b_stall", {31'd0, stall_out}, 32'd1);
    tick();
    r_op(F_ADD, 5'd31, 32'd0, 5'd0, 32'd1, 5'd1);
    wait_mul(n_edges, n_stall);
    chk("b2b_edges", 32'(n_edges), 32'd31);
    chk("b2b_res", ALUResult_out, 32'd15);
    chk("b2b_rd", {27'd0, Rd_addr_out}, 32'd31);
    tick();
    chk("b2b_fwd", ALUResult_out, 32'd16);

    // Reset in the middle of a multiply
    r_op(F_MUL, 5'd2, 32'd9, 5'd3, 32'd9, 5'd4);
    tick();
    for (int i = 0; i < 9; i++) tick();
    #1;
    chk("midrst_busy", {31'd0, stall_out}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk_zero("midrst");
    rst = 1'b1;
    r_op(F_ADD, 5'd2, 32'd9, 5'd3, 32'd9, 5'd4);
    #1;
    chk("postrst_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("postrst_res", ALUResult_out, 32'd18);
    chk("postrst_rw", {31'd0, RegWrite_out}, 32'd1);

    // Signed overflow on funct add
    r_op(F_ADD, 5'd5, 32'h7FFFFFFF, 5'd6, 32'd1, 5'd7);
    tick();
`ifdef EX_OVF_EN
    chk("ovf_rw", {31'd0, RegWrite_out}, 32'd0);
    chk("ovf_flag", {31'd0, ovf_out}, 32'd1);
`else
    chk("wrap_res", ALUResult_out, 32'h80000000);
    chk("wrap_rw", {31'd0, RegWrite_out}, 32'd1);
`endif
    r_op(F_ADD, 5'd5, 32'd1, 5'd6, 32'd1, 5'd8);
    tick();
    chk("after_ovf_res", ALUResult_out, 32'd2);
    chk("after_ovf_rw", {31'd0, RegWrite_out}, 32'd1);
`ifdef EX_OVF_EN
    chk("ovf_sticky", {31'd0, ovf_out}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
